// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the mux_scan_reg block:
//   - FSM state encoding (also the value seen on mux_scan_reg.state_dbg)
//   - mode constants for the 'mode' input
//   - clog2 helper used to size select/counter ports
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2 usable in parameter defaults; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// -----------------------------------------------------------------------------
// mux_nto1_comb
// Purely combinational N:1 selector of W-bit channels, MSB-first:
// select value s returns channel N-1-s, i.e. a[(N-1-s)*W +: W].
// Selects outside 0..N-1 return zero.
// Ports:
//   a   in  N*W  packed channels, channel k at a[k*W +: W]
//   sel in  SW   select value
//   y   out W    selected channel (or zero)
// -----------------------------------------------------------------------------
module mux_nto1_comb #(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int SW = 3
) (
  input  logic [N*W-1:0] a,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y
);

  // Compare-and-pick loop; an out-of-range select matches no
  // iteration and leaves the zero default in place.
  always_comb begin
    y = '0;
    for (int s = 0; s < N; s++) begin
      if (int'(sel) == s) y = a[(N-1-s)*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan_reg.sv
// -----------------------------------------------------------------------------
// mux_scan_reg
// N-channel, W-bit registered multiplexer with a valid/ready output.
//   Direct mode: one sample of channel N-1-S per req.
//   Scan mode:   a sequencer visits select values 0..N-1, waiting 'dwell'
//                cycles before each sample, optionally wrapping (cont).
// Optional build macro: MUX_TAG_EN adds output Y_tag, the select value that
// produced the current Y.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   A [N*W]            packed channels, channel k at A[k*W +: W]
//   mode               0 direct, 1 scan (only looked at in IDLE)
//   S, req             direct-mode select and sample request
//   start, cont, dwell scan start pulse, wrap enable, dwell length
//   abort              return to IDLE from any busy state
//   Y, Y_valid, Y_ready  output sample handshake
//   cur_sel            select value currently addressed by the sequencer
//   busy, done         not-IDLE flag, end-of-scan pulse
//   Y_tag              (MUX_TAG_EN only) select value of the sample in Y
//   state_dbg          current FSM state (mux_pkg ST_* encoding)
//
// Handshake: Y_valid=1 means Y holds a sample not yet taken; the sample is
// taken on a rising edge where Y_valid && Y_ready. Y and Y_valid never change
// while Y_valid=1 and Y_ready=0. A new sample may be loaded in the same cycle
// the previous one is taken, giving one sample per cycle.
// -----------------------------------------------------------------------------
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int SW = clog2(N),
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] A,
  input  logic           mode,
  input  logic [SW-1:0]  S,
  input  logic           req,
  input  logic           start,
  input  logic           cont,
  input  logic           abort,
  input  logic [DW-1:0]  dwell,
  output logic [W-1:0]   Y,
  output logic           Y_valid,
  input  logic           Y_ready,
  output logic [SW-1:0]  cur_sel,
  output logic           busy,
  output logic           done,
`ifdef MUX_TAG_EN
  output logic [SW-1:0]  Y_tag,
`endif
  output logic [1:0]     state_dbg
);

  localparam logic [SW-1:0] LAST_SEL = SW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          cont_q, cont_d;
  logic [W-1:0]  y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic          done_q, done_d;

  logic [SW-1:0] mux_sel;
  logic [W-1:0]  mux_y;
  logic          slot_free;
  logic          load;

  assign slot_free = !y_valid_q || Y_ready;

  mux_nto1_comb #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_sel (
    .a   (A),
    .sel (mux_sel),
    .y   (mux_y)
  );

  // Sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    sel_d   = sel_q;
    cont_d  = cont_q;
    done_d  = 1'b0;
    load    = 1'b0;
    mux_sel = S;

    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_DIRECT) begin
          // A request that finds the slot occupied is dropped, not queued.
          if (req && slot_free) load = 1'b1;
        end else if (mode == MODE_SCAN && start) begin
          state_d = ST_DWELL;
          sel_d   = '0;
          cnt_d   = dwell;
          dwell_d = dwell;
          cont_d  = cont;
        end
      end
      ST_DWELL: begin
        if (cnt_q == '0) state_d = ST_EMIT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_EMIT: begin
        mux_sel = sel_q;
        if (slot_free) begin
          load  = 1'b1;
          cnt_d = dwell_q;
          if (sel_q != LAST_SEL) begin
            sel_d   = sel_q + 1'b1;
            state_d = ST_DWELL;
          end else if (cont_q) begin
            sel_d   = '0;
            state_d = ST_DWELL;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (slot_free) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything; a sample already in Y stays there.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      load    = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Output register
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    if (load) begin
      y_d       = mux_y;
      y_valid_d = 1'b1;
    end else if (Y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dwell_q   <= '0;
      sel_q     <= '0;
      cont_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
      sel_q     <= sel_d;
      cont_q    <= cont_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      done_q    <= done_d;
    end
  end

`ifdef MUX_TAG_EN
  // Tag carries the raw select, including out-of-range values.
  logic [SW-1:0] tag_q, tag_d;

  always_comb begin
    tag_d = tag_q;
    if (load) tag_d = mux_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  assign Y_tag = tag_q;
`endif

  assign Y         = y_q;
  assign Y_valid   = y_valid_q;
  assign cur_sel   = sel_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
Parametrised N-channel, W-bit registered multiplexer with a ready/valid output.
- Direct mode: one sample of the channel chosen by S per request.
- Scan mode: internal sequencer walks every channel with a programmable dwell time and emits one sample per channel.
- Sits between sensor/data banks and downstream serial or processing logic.
- Channel ordering is MSB-first: select value s picks channel N-1-s, i.e. A[(N-1-s)*W +: W]. This matches the existing 8:1 gate-level mux.

Parameters:
N, 8, number of input channels (2..64)
W, 1, bits per channel
SW, $clog2(N), select/counter width
DW, 8, dwell counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
A  in  N*W  packed channel inputs; channel k occupies A[k*W +: W]
mode  in  1  0 = direct, 1 = scan; sampled only in IDLE
S  in  SW  direct-mode select
req  in  1  direct-mode sample request
start  in  1  scan start pulse
cont  in  1  scan continuous (wrap) enable; sampled at start
abort  in  1  return to IDLE
dwell  in  DW  cycles to wait before each scan sample; sampled at start
Y  out  W  registered sample
Y_valid  out  1  Y holds an unconsumed sample
Y_ready  in  1  downstream accepts Y
cur_sel  out  SW  select value currently addressed
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last scan sample is accepted

Behaviour:
- Reset values: Y=0, Y_valid=0, cur_sel=0, busy=0, done=0, state=IDLE, dwell counter=0.
- Output slot is free when !Y_valid || Y_ready.
- Load: Y captures the selected channel, Y_valid=1 the next cycle.
- Consume: Y_valid clears on Y_ready unless a load happens in the same cycle; back-to-back throughput is 1/cycle.
- Out-of-range select (s >= N, possible when N is not a power of 2): Y loads 0, and the sample still counts as emitted.
- Y is stable while Y_valid=1 and Y_ready=0.
- States:
  - IDLE: mode=0 and req and slot free -> load channel N-1-S; stay in IDLE. Latency req->Y_valid is 1 cycle. req with slot busy is dropped (no queue).
  - IDLE, mode=1 and start -> DWELL. cur_sel=0; latch dwell and cont; load counter with dwell.
  - DWELL: counter decrements each cycle. At 0 -> EMIT. dwell=0 skips straight to EMIT on the next cycle.
  - EMIT: wait for a free slot, then load channel N-1-cur_sel. Then:
    - cur_sel < N-1: increment cur_sel, reload counter, go to DWELL.
    - cur_sel = N-1 and cont=1: cur_sel wraps to 0, go to DWELL.
    - cur_sel = N-1 and cont=0: go to DRAIN.
  - DRAIN: wait until Y_valid=0 or Y_ready, then pulse done and go to IDLE.
- abort (highest priority, any state except IDLE) -> IDLE next cycle. cur_sel=0; a pending Y/Y_valid is retained, not flushed; done is not pulsed.
- start while busy, and req in scan mode, are ignored.
- mode is ignored outside IDLE.
- Reset mid-operation asynchronously clears all state and outputs to their reset values.

Optional Feature:
MUX_TAG_EN
- Defined: adds output Y_tag [SW-1:0], loaded with the select value of the sample together with Y (reset 0). Out-of-range selects tag the raw select value.
- Undefined: port absent; no tag register.

Decomposition:
- Package mux_pkg: state encoding (IDLE, DWELL, EMIT, DRAIN), MODE_DIRECT/MODE_SCAN constants, clog2 helper.
- One sub-module, mux_nto1_comb: purely combinational N:1 W-bit selector with MSB-first mapping and zero for out-of-range selects. Instantiated once.
- FSM, counters and output register live in the top module.

Test Plan:
- Direct, N=8, W=1, A=8'b1000_0000, S=0, req, Y_ready=1 -> next cycle Y=1, Y_valid=1; S=7 -> Y=0.
- Scan, N=4, W=8, A={8'h44,8'h33,8'h22,8'h11}, dwell=2, cont=0, Y_ready=1 -> Y sequence 44,33,22,11, spaced 4 cycles apart (dwell plus EMIT); done one cycle after the last is accepted; busy low afterwards.
- Backpressure: scan with Y_ready=0 for 5 cycles after the first sample -> Y holds 44, FSM stays in EMIT, no sample lost; release -> sequence continues at 33.
- cont=1, N=3 -> cur_sel cycles 0,1,2,0,1...; no done; abort mid-DWELL -> IDLE next cycle, busy=0, done=0.
- N=6, S=6 and S=7 in direct mode -> Y=0 loaded, Y_valid=1; with MUX_TAG_EN, Y_tag=6 and 7 respectively.
- Assert rst_n low during EMIT with Y_valid=1 -> Y=0, Y_valid=0, state IDLE immediately; operation resumes cleanly after rst_n release.
